// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding the serial_tx UART transmitter: producers push bytes at up to
// one per clock, a small sequencer drains them in order through the sbyte handshake.
module serial_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk12,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  busy,
    output logic [7:0]            tx_byte,
    output logic                  tx_byte_rdy,
    input  logic                  tx_end_of_send,
    output logic [1:0]            dbg_state
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Handshake toward serial_tx: tx_byte is valid whenever tx_byte_rdy is high and
    // stays stable until the matching tx_end_of_send; tx_byte_rdy is a one-cycle pulse
    // and tx_end_of_send is honoured only in WAIT.
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            state_q, state_d;
    logic [7:0]            tx_byte_q, tx_byte_d;

    logic                  full_w;
    logic                  wr_accept;
    logic                  pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        full_w    = (count_q == DEPTH_CNT);
        wr_accept = wr_en && !full_w;
        pop       = (state_q == ST_IDLE) && (count_q != '0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end

        count_d = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_byte_d = mem_q[rd_ptr_q];
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_end_of_send) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            tx_byte_q  <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk12) begin
        if (wr_accept && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        full        = full_w;
        empty       = (count_q == '0);
        count       = count_q;
        overflow    = overflow_q;
        busy        = (state_q != ST_IDLE);
        tx_byte     = tx_byte_q;
        tx_byte_rdy = (state_q == ST_SEND);
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: cycle vectors, directed corner sequences and a random
// phase, all checked against a queue-based reference model.
module tb_serial_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic       clk12 = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_overflow = 1'b0;
  logic       eos_manual = 1'b0;
  logic       eos_auto = 1'b0;
  logic       tx_end_of_send;
  logic       full, empty, overflow, busy, tx_byte_rdy;
  logic [DEPTH_LOG2:0] count;
  logic [7:0] tx_byte;
  logic [1:0] dbg_state;

  assign tx_end_of_send = eos_manual | eos_auto;

  serial_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk12(clk12), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow), .busy(busy), .tx_byte(tx_byte),
    .tx_byte_rdy(tx_byte_rdy), .tx_end_of_send(tx_end_of_send),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #5 clk12 = ~clk12;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queued bytes, byte in flight, pulse phase, sticky overflow
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  bit         m_inflight = 0;
  bit         m_pulse = 0;
  bit         m_ovf = 0;
  logic [7:0] m_tx = 8'h00;
  bit         model_valid = 0;
  bit         gap_en = 0;
  int         cyc = 0;
  int         last_eos = -1;

  always @(negedge clk12) begin
    bit full_now;
    bit do_pop;
    cyc++;
    if (model_valid) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("busy", 32'(busy), 32'(m_inflight));
      check("tx_byte_rdy", 32'(tx_byte_rdy), 32'(m_pulse));
      check("tx_byte", 32'(tx_byte), 32'(m_tx));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("dbg_state", 32'(dbg_state), !m_inflight ? 32'd0 : (m_pulse ? 32'd1 : 32'd2));
      if (tx_byte_rdy === 1'b1) begin
        sent_q.push_back(tx_byte);
        if (gap_en && last_eos >= 0) begin
          check("eos_to_rdy_gap", 32'(cyc - last_eos), 32'd2);
          last_eos = -1;
        end
      end
      if (tx_end_of_send && m_inflight && !m_pulse && exp_q.size() != 0) last_eos = cyc;
    end
    if (reset) begin
      exp_q.delete();
      m_inflight = 0;
      m_pulse = 0;
      m_tx = 8'h00;
      m_ovf = 0;
      model_valid = 1;
    end else begin
      full_now = (exp_q.size() == DEPTH);
      do_pop = !m_inflight && exp_q.size() != 0;
      if (m_inflight && !m_pulse && tx_end_of_send) m_inflight = 0;
      m_pulse = 0;
      if (do_pop) begin
        m_tx = exp_q.pop_front();
        m_inflight = 1;
        m_pulse = 1;
      end
      if (wr_en && !full_now) exp_q.push_back(wr_data);
      if (wr_en && full_now) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
    end
  end

  // serial_tx stand-in: answers each tx_byte_rdy after a random delay
  bit auto_en = 0;
  int eos_min = 1;
  int eos_max = 6;
  initial begin : responder
    int d;
    forever begin
      @(posedge clk12);
      #2;
      if (auto_en && tx_byte_rdy === 1'b1) begin
        d = $urandom_range(eos_max, eos_min);
        repeat (d) @(posedge clk12);
        #2 eos_auto = 1'b1;
        @(posedge clk12);
        #2 eos_auto = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk12);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_eos();
    eos_manual = 1'b1;
    tick();
    eos_manual = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n = 0;
    while (!(empty === 1'b1 && busy === 1'b0) && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(n < max_cyc), 32'd1);
  endtask

  typedef struct {
    logic rst; logic we; logic [7:0] wd; logic clr; logic eos;
    int cnt; logic ful; logic emp; logic bsy; logic rdy; logic [7:0] txb; logic ovf;
  } vec_t;

  vec_t vt[13];
  logic [7:0] hello[13];

  initial begin : main
    string s;
    int rate;
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 8'h48, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h48, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h48, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h48, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h48, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h48, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h48, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0};
    vt[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0};
    vt[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0};
    s = "Hello World!*";
    for (int i = 0; i < 13; i++) hello[i] = s[i];

    tick();
    // single byte, spurious end_of_send in IDLE and in SEND
    for (int i = 0; i < 13; i++) begin
      reset = vt[i].rst; wr_en = vt[i].we; wr_data = vt[i].wd;
      clr_overflow = vt[i].clr; eos_manual = vt[i].eos;
      tick();
      check($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].ful));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].emp));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
      check($sformatf("v%0d_rdy", i), 32'(tx_byte_rdy), 32'(vt[i].rdy));
      check($sformatf("v%0d_tx_byte", i), 32'(tx_byte), 32'(vt[i].txb));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].ovf));
    end
    reset = 0; wr_en = 0; clr_overflow = 0; eos_manual = 0;

    // order and burst with 20-200 cycle serial latency
    do_reset();
    sent_q.delete();
    eos_min = 20; eos_max = 200; auto_en = 1; gap_en = 1; last_eos = -1;
    for (int i = 0; i < 13; i++) begin
      wr_en = 1'b1; wr_data = hello[i];
      tick();
    end
    wr_en = 1'b0;
    wait_drain(13 * 210 + 50, "hello_drain_timeout");
    gap_en = 0; auto_en = 0;
    check("hello_sent_count", 32'(sent_q.size()), 32'd13);
    for (int i = 0; i < 13 && i < sent_q.size(); i++)
      check($sformatf("hello_byte%0d", i), 32'(sent_q[i]), 32'(hello[i]));

    // full and overflow
    do_reset();
    sent_q.delete();
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("full_count", 32'(count), 32'd16);
    check("full_flag", 32'(full), 32'd1);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_inflight", 32'(tx_byte), 32'h00);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_count_kept", 32'(count), 32'd16);
    eos_min = 1; eos_max = 6; auto_en = 1;
    pulse_eos();
    wait_drain(17 * 12 + 50, "full_drain_timeout");
    auto_en = 0;
    check("full_sent_count", 32'(sent_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < sent_q.size(); i++)
      check($sformatf("full_byte%0d", i), 32'(sent_q[i]), 32'(i));

    // write in the same cycle as the pop
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA1;
    tick();
    wr_data = 8'hB2;
    tick();
    wr_en = 1'b0;
    check("simul_count", 32'(count), 32'd1);
    check("simul_rdy_a", 32'(tx_byte_rdy), 32'd1);
    check("simul_tx_a", 32'(tx_byte), 32'hA1);
    tick();
    tick();
    pulse_eos();
    tick();
    check("simul_rdy_b", 32'(tx_byte_rdy), 32'd1);
    check("simul_tx_b", 32'(tx_byte), 32'hB2);
    tick();
    pulse_eos();
    check("simul_done_busy", 32'(busy), 32'd0);
    check("simul_done_empty", 32'(empty), 32'd1);

    // reset while waiting on the line, then a late end_of_send
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("rst_pre_state", 32'(dbg_state), 32'd2);
    check("rst_pre_count", 32'(count), 32'd4);
    sent_q.delete();
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    pulse_eos();
    repeat (6) tick();
    check("rst_late_count", 32'(count), 32'd0);
    check("rst_late_state", 32'(dbg_state), 32'd0);
    check("rst_late_pulses", 32'(sent_q.size()), 32'd0);

    // spurious handshakes while idle and empty
    for (int i = 0; i < 3; i++) begin
      pulse_eos();
      tick();
    end
    check("spur_state", 32'(dbg_state), 32'd0);
    check("spur_pulses", 32'(sent_q.size()), 32'd0);

    // random traffic against the model
    eos_min = 1; eos_max = 6; auto_en = 1;
    for (int i = 0; i < 900; i++) begin
      if (i % 100 == 0) rate = (i / 100) % 3 == 0 ? 20 : ((i / 100) % 3 == 1 ? 60 : 95);
      wr_en = ($urandom_range(99, 0) < rate);
      wr_data = 8'($urandom_range(255, 0));
      clr_overflow = ($urandom_range(29, 0) == 0);
      tick();
    end
    wr_en = 1'b0; clr_overflow = 1'b0;
    wait_drain(DEPTH * 12 + 50, "rand_drain_timeout");
    auto_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
